par_read_circ_buffer: RTL

//   Circular buffer of COLUMNS words: single-word writes, PAR_READ-word parallel read window.

---
 rtl/par_read_circ_buffer.sv | 94 +++++++++
 1 files changed

// File: rtl/par_read_circ_buffer.sv
// Circular buffer with single-word writes and a PAR_READ-word zero-latency read window.
// The read pointer comes from an external updater; a shadow copy catches any divergence.

module par_read_circ_buffer_lane #(
  parameter int COLUMNS = 32,
  parameter int OFFSET  = 0
) (
  input  logic [$clog2(COLUMNS)-1:0] read_ptr,
  output logic [$clog2(COLUMNS)-1:0] idx
);
  localparam int AW = $clog2(COLUMNS);
  localparam int CW = AW + 1;

  logic [CW-1:0] sum;

  // One extra bit plus a single conditional subtract wraps correctly for non-power-of-2 depths.
  assign sum = {1'b0, read_ptr} + CW'(OFFSET);
  assign idx = (sum >= CW'(COLUMNS)) ? AW'(sum - CW'(COLUMNS)) : sum[AW-1:0];
endmodule

module par_read_circ_buffer #(
  parameter int COLUMNS    = 32,
  parameter int PAR_READ   = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_valid,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  output logic                           wr_ready,
  input  logic [$clog2(COLUMNS)-1:0]     read_ptr,
  output logic                           rd_valid,
  input  logic                           rd_ready,
  output logic [PAR_READ*DATA_WIDTH-1:0] rd_data,
  output logic                           updateRP,
  output logic [$clog2(COLUMNS):0]       count,
  output logic                           full,
  output logic                           empty,
  output logic                           sync_err
);
  localparam int AW = $clog2(COLUMNS);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] COLS = CW'(COLUMNS);
  localparam logic [CW-1:0] PR   = CW'(PAR_READ);

  logic [DATA_WIDTH-1:0] mem [COLUMNS];
  logic [AW-1:0]         wr_ptr, wr_ptr_nxt;
  logic [AW-1:0]         shadow_rp, shadow_nxt;
  logic [CW-1:0]         cnt, cnt_nxt, shadow_sum;
  logic                  wr_fire;

  assign wr_ready = (cnt < COLS);
  assign rd_valid = (cnt >= PR);
  assign updateRP = rd_valid && rd_ready;
  assign wr_fire  = wr_valid && wr_ready;
  assign count    = cnt;
  assign full     = (cnt == COLS);
  assign empty    = (cnt == '0);

  always_comb begin
    cnt_nxt    = cnt + CW'(wr_fire) - (updateRP ? PR : '0);
    wr_ptr_nxt = (wr_ptr == AW'(COLUMNS - 1)) ? '0 : wr_ptr + 1'b1;
    shadow_sum = {1'b0, shadow_rp} + PR;
    shadow_nxt = (shadow_sum >= COLS) ? AW'(shadow_sum - COLS) : shadow_sum[AW-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      cnt       <= '0;
      shadow_rp <= '0;
      sync_err  <= 1'b0;
    end else begin
      if (wr_fire)  wr_ptr    <= wr_ptr_nxt;
      if (updateRP) shadow_rp <= shadow_nxt;
      cnt <= cnt_nxt;
      if (read_ptr != shadow_rp) sync_err <= 1'b1;
    end
  end

  // Storage is never cleared; the pointers and count define what is live.
  always_ff @(posedge clk) begin
    if (wr_fire && !rst) mem[wr_ptr] <= wr_data;
  end

  for (genvar i = 0; i < PAR_READ; i++) begin : g_lane
    logic [AW-1:0] idx;
    par_read_circ_buffer_lane #(.COLUMNS(COLUMNS), .OFFSET(i)) u_lane (
      .read_ptr (read_ptr),
      .idx      (idx)
    );
    assign rd_data[i*DATA_WIDTH +: DATA_WIDTH] = mem[idx];
  end
endmodule
